mul_arbiter: RTL and testbench

MUL_ARBITER -- requirements
Module: mul_arbiter

---
 rtl/mul_arbiter_if.sv | 38 +++
 rtl/mul_arbiter.sv | 140 ++++++++++++++
 tb/tb_mul_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mul_arbiter_if.sv
// mul_arbiter_if: requester, response and shared-multiplier signals of the
// two-requester multiply arbiter. The slave modport is the arbiter's view;
// the master modport is the view of the surrounding requesters, consumer
// and multiplier.
interface mul_arbiter_if;
  logic        req0_valid;
  logic [15:0] req0_a;
  logic [15:0] req0_b;
  logic        req0_ready;
  logic        req1_valid;
  logic [15:0] req1_a;
  logic [15:0] req1_b;
  logic        req1_ready;
  logic        rsp_valid;
  logic        rsp_id;
  logic [31:0] rsp_result;
  logic        rsp_err;
  logic        rsp_ready;
  logic [15:0] mul_a;
  logic [15:0] mul_b;
  logic        mul_load;
  logic        mul_wait;
  logic [31:0] mul_result;

  modport slave (
    input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b,
    input  rsp_ready, mul_wait, mul_result,
    output req0_ready, req1_ready, rsp_valid, rsp_id, rsp_result, rsp_err,
    output mul_a, mul_b, mul_load
  );

  modport master (
    output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b,
    output rsp_ready, mul_wait, mul_result,
    input  req0_ready, req1_ready, rsp_valid, rsp_id, rsp_result, rsp_err,
    input  mul_a, mul_b, mul_load
  );
endinterface

// File: rtl/mul_arbiter.sv
// mul_arbiter: round-robin arbiter granting two requesters access to one
// shared shift-add multiplier, with a per-multiply watchdog (MAX_CYC cycles
// in RUN). One multiply is outstanding at a time.
// Optional feature: define MUL_ARBITER_ZERO_BYPASS_EN to answer requests with
// a zero operand directly (result 0) without loading the multiplier.
module mul_arbiter #(
  parameter int unsigned MAX_CYC = 20
) (
  input  logic         clk,
  input  logic         rst_n,
  mul_arbiter_if.slave bus
);

  localparam int unsigned CW = $clog2(MAX_CYC + 1);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, RESP} state_t;

  state_t        state_q, state_d;
  logic          ptr_q;
  logic [15:0]   a_q, b_q;
  logic          id_q;
  logic [31:0]   res_q;
  logic          err_q;
  logic [CW-1:0] cnt_q;

  logic          grant_id;
  logic [15:0]   sel_a, sel_b;
  logic          accept, capture, timeout, rsp_done;
  logic          in_resp;

  // Grant selection: pointer breaks ties, a sole valid requester always wins
  always_comb begin
    grant_id = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      grant_id = ptr_q;
    end else if (bus.req1_valid) begin
      grant_id = 1'b1;
    end
    sel_a = grant_id ? bus.req1_a : bus.req0_a;
    sel_b = grant_id ? bus.req1_b : bus.req0_b;
  end

  // Next-state logic and per-cycle strobes; READY only from IDLE and never in reset
  always_comb begin
    state_d        = state_q;
    accept         = 1'b0;
    capture        = 1'b0;
    timeout        = 1'b0;
    rsp_done       = 1'b0;
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rst_n && (bus.req0_valid || bus.req1_valid)) begin
          accept         = 1'b1;
          bus.req0_ready = ~grant_id;
          bus.req1_ready = grant_id;
`ifdef MUL_ARBITER_ZERO_BYPASS_EN
          state_d = ((sel_a == '0) || (sel_b == '0)) ? RESP : LOAD;
`else
          state_d = LOAD;
`endif
        end
      end
      LOAD: state_d = RUN;
      RUN: begin
        if (!bus.mul_wait) begin
          capture = 1'b1;
          state_d = RESP;
        end else if (cnt_q == CW'(MAX_CYC)) begin
          timeout = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_done = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Operand/response latches, watchdog counter and round-robin pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= 1'b0;
      a_q   <= '0;
      b_q   <= '0;
      id_q  <= 1'b0;
      res_q <= '0;
      err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      if (accept) begin
        // Result is cleared here so a bypassed zero request answers 0
        a_q   <= sel_a;
        b_q   <= sel_b;
        id_q  <= grant_id;
        res_q <= '0;
        err_q <= 1'b0;
      end
      if (state_q == LOAD) begin
        cnt_q <= CW'(1);
      end else if (state_q == RUN && state_d == RUN) begin
        cnt_q <= cnt_q + CW'(1);
      end
      if (capture) begin
        res_q <= bus.mul_result;
      end
      if (timeout) begin
        res_q <= '0;
        err_q <= 1'b1;
      end
      if (rsp_done) begin
        ptr_q <= ~id_q;
      end
    end
  end

  assign in_resp        = (state_q == RESP);
  assign bus.rsp_valid  = in_resp;
  assign bus.rsp_id     = in_resp & id_q;
  assign bus.rsp_err    = in_resp & err_q;
  assign bus.rsp_result = in_resp ? res_q : '0;
  assign bus.mul_load   = (state_q == LOAD);
  assign bus.mul_a      = a_q;
  assign bus.mul_b      = b_q;

endmodule

// File: tb/tb_mul_arbiter.sv
// tb_mul_arbiter: randomized and directed bench for mul_arbiter with a
// behavioural shift-add multiplier and a transaction-level reference model.
`timescale 1ns/1ps
module tb_mul_arbiter;
  localparam int unsigned MAXC = 20;
`ifdef MUL_ARBITER_ZERO_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic stuck;
  always #5 clk = ~clk;

  mul_arbiter_if ifc();
  mul_arbiter #(.MAX_CYC(MAXC)) dut (.clk(clk), .rst_n(rst_n), .bus(ifc));

  // Shared shift-add multiplier: busy while remaining B bits are nonzero
  logic [31:0] m_acc, m_a;
  logic [15:0] m_b;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_acc <= '0; m_a <= '0; m_b <= '0;
    end else if (ifc.mul_load) begin
      m_acc <= '0; m_a <= {16'h0, ifc.mul_a}; m_b <= ifc.mul_b;
    end else if (m_b != 16'h0) begin
      if (m_b[0]) m_acc <= m_acc + m_a;
      m_a <= m_a << 1;
      m_b <= m_b >> 1;
    end
  end
  assign ifc.mul_wait   = stuck | (m_b != 16'h0);
  assign ifc.mul_result = m_acc;

  // Transaction monitor
  int cyc = 0, loads = 0, dbl = 0;
  int gq_id[$], gq_cyc[$], rq_id[$], rq_err[$], rq_cyc[$];
  logic [31:0] rq_res[$];
  always @(negedge clk) begin
    cyc++;
    if (ifc.mul_load) loads++;
    if (ifc.req0_ready && ifc.req1_ready) dbl++;
    if (ifc.req0_valid && ifc.req0_ready) begin gq_id.push_back(0); gq_cyc.push_back(cyc); end
    if (ifc.req1_valid && ifc.req1_ready) begin gq_id.push_back(1); gq_cyc.push_back(cyc); end
    if (ifc.rsp_valid && ifc.rsp_ready) begin
      rq_id.push_back(int'(ifc.rsp_id)); rq_err.push_back(int'(ifc.rsp_err));
      rq_res.push_back(ifc.rsp_result); rq_cyc.push_back(cyc);
    end
  end

  int n_tests = 0, n_fail = 0;
  bit ptr_m = 1'b0;

  // Reference: cycles from grant to response handshake with RSP_READY held high
  function automatic int exp_lat(input logic [15:0] a, input logic [15:0] b, input bit stk);
    int bl;
    bl = 0;
    if (BYP && (a == 16'h0 || b == 16'h0)) return 1;
    if (stk) return 2 + int'(MAXC);
    for (int i = 0; i < 16; i++) if (b[i]) bl = i + 1;
    return 2 + bl + 1;
  endfunction

  function automatic int exp_loads(input logic [15:0] a, input logic [15:0] b);
    return (BYP && (a == 16'h0 || b == 16'h0)) ? 0 : 1;
  endfunction

  task automatic set_req(input bit id, input bit v, input logic [15:0] a, input logic [15:0] b);
    if (id) begin ifc.req1_valid = v; ifc.req1_a = a; ifc.req1_b = b; end
    else    begin ifc.req0_valid = v; ifc.req0_a = a; ifc.req0_b = b; end
  endtask

  task automatic wait_grant(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk); #1;
      if (ifc.req0_ready || ifc.req1_ready) ok = 1'b1;
    end
  endtask

  task automatic wait_rsp(input int n0, input bit rnd, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(posedge clk); #1;
      if (rnd) ifc.rsp_ready = 1'($urandom_range(0, 1));
      @(negedge clk); #1;
      if (rq_id.size() > n0) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; stuck = 1'b0; ifc.rsp_ready = 1'b0;
    set_req(0, 0, '0, '0); set_req(1, 0, '0, '0);
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    n_tests++; if ({ifc.req0_ready, ifc.req1_ready, ifc.rsp_valid, ifc.rsp_id, ifc.rsp_err, ifc.mul_load} !== 6'b0) begin n_fail++; $display("FAIL reset_ctrl got=%b exp=0", {ifc.req0_ready, ifc.req1_ready, ifc.rsp_valid, ifc.rsp_id, ifc.rsp_err, ifc.mul_load}); end
    n_tests++; if (ifc.rsp_result !== 32'h0) begin n_fail++; $display("FAIL reset_result got=%0h exp=0", ifc.rsp_result); end
    n_tests++; if ({ifc.mul_a, ifc.mul_b} !== 32'h0) begin n_fail++; $display("FAIL reset_mul_ops got=%0h exp=0", {ifc.mul_a, ifc.mul_b}); end
    set_req(0, 1, 16'h1, 16'h1); set_req(1, 1, 16'h1, 16'h1);
    @(negedge clk); #1;
    n_tests++; if ({ifc.req0_ready, ifc.req1_ready} !== 2'b00) begin n_fail++; $display("FAIL reset_ready got=%b exp=00", {ifc.req0_ready, ifc.req1_ready}); end
    set_req(0, 0, '0, '0); set_req(1, 0, '0, '0);
  endtask

  task automatic test_basic();
    int n0, g0, l0;
    bit ok;
    n0 = rq_id.size(); g0 = gq_id.size(); l0 = loads;
    @(posedge clk); #1;
    rst_n = 1'b1; ifc.rsp_ready = 1'b1; set_req(0, 1, 16'd3, 16'd5);
    @(negedge clk); #1;
    n_tests++; if (ifc.req0_ready !== 1'b1) begin n_fail++; $display("FAIL first_grant got=%b exp=1", ifc.req0_ready); end
    @(posedge clk); #1;
    set_req(0, 0, '0, '0);
    wait_rsp(n0, 0, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL basic_timeout got=none exp=response"); end
    if (ok && gq_id.size() > g0) begin
      n_tests++; if (rq_id[n0] !== 0) begin n_fail++; $display("FAIL basic_id got=%0d exp=0", rq_id[n0]); end
      n_tests++; if (rq_res[n0] !== 32'd15) begin n_fail++; $display("FAIL basic_result got=%0d exp=15", rq_res[n0]); end
      n_tests++; if (rq_err[n0] !== 0) begin n_fail++; $display("FAIL basic_err got=%0d exp=0", rq_err[n0]); end
      n_tests++; if (rq_cyc[n0] - gq_cyc[g0] !== exp_lat(16'd3, 16'd5, 0)) begin n_fail++; $display("FAIL basic_latency got=%0d exp=%0d", rq_cyc[n0] - gq_cyc[g0], exp_lat(16'd3, 16'd5, 0)); end
      n_tests++; if (loads - l0 !== 1) begin n_fail++; $display("FAIL basic_loads got=%0d exp=1", loads - l0); end
    end
    ptr_m = 1'b1;
  endtask

  task automatic test_single(input string nm, input bit id, input logic [15:0] a, input logic [15:0] b, input bit stk);
    int n0, g0, l0, lat;
    bit ok;
    logic [31:0] exp_res;
    exp_res = stk ? 32'h0 : {16'h0, a} * {16'h0, b};
    lat = exp_lat(a, b, stk);
    stuck = stk;
    n0 = rq_id.size(); g0 = gq_id.size(); l0 = loads;
    @(posedge clk); #1;
    ifc.rsp_ready = 1'b1; set_req(id, 1, a, b);
    wait_grant(ok);
    @(posedge clk); #1;
    set_req(id, 0, '0, '0);
    if (ok) wait_rsp(n0, 0, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL %s_timeout got=none exp=response", nm); end
    if (ok && gq_id.size() > g0) begin
      n_tests++; if (rq_id[n0] !== int'(id)) begin n_fail++; $display("FAIL %s_id got=%0d exp=%0d", nm, rq_id[n0], id); end
      n_tests++; if (rq_res[n0] !== exp_res) begin n_fail++; $display("FAIL %s_result got=%0h exp=%0h", nm, rq_res[n0], exp_res); end
      n_tests++; if (rq_err[n0] !== int'(stk)) begin n_fail++; $display("FAIL %s_err got=%0d exp=%0d", nm, rq_err[n0], stk); end
      n_tests++; if (rq_cyc[n0] - gq_cyc[g0] !== lat) begin n_fail++; $display("FAIL %s_latency got=%0d exp=%0d", nm, rq_cyc[n0] - gq_cyc[g0], lat); end
      n_tests++; if (loads - l0 !== exp_loads(a, b)) begin n_fail++; $display("FAIL %s_loads got=%0d exp=%0d", nm, loads - l0, exp_loads(a, b)); end
    end
    stuck = 1'b0;
    ptr_m = ~id;
  endtask

  task automatic test_zero();
    test_single("zero", 1'b1, 16'd7, 16'd0, 1'b0);
  endtask

  task automatic test_watchdog();
    test_single("wdog", 1'b1, 16'd9, 16'd9, 1'b1);
  endtask

  task automatic test_alternate();
    int n0, g0;
    bit ok, exp_id;
    n0 = rq_id.size(); g0 = gq_id.size();
    @(posedge clk); #1;
    ifc.rsp_ready = 1'b1; set_req(0, 1, 16'hFFFF, 16'hFFFF); set_req(1, 1, 16'hFFFF, 16'hFFFF);
    ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk); #1;
      if (rq_id.size() >= n0 + 4) ok = 1'b1;
    end
    @(posedge clk); #1;
    set_req(0, 0, '0, '0); set_req(1, 0, '0, '0);
    repeat (3) @(posedge clk);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL alt_timeout got=%0d exp=4 responses", rq_id.size() - n0); end
    n_tests++; if (gq_id.size() !== g0 + 4) begin n_fail++; $display("FAIL alt_grant_count got=%0d exp=4", gq_id.size() - g0); end
    if (ok && gq_id.size() >= g0 + 4) begin
      exp_id = ptr_m;
      for (int k = 0; k < 4; k++) begin
        n_tests++; if (gq_id[g0 + k] !== int'(exp_id)) begin n_fail++; $display("FAIL alt_grant%0d got=%0d exp=%0d", k, gq_id[g0 + k], exp_id); end
        n_tests++; if (rq_id[n0 + k] !== int'(exp_id)) begin n_fail++; $display("FAIL alt_rspid%0d got=%0d exp=%0d", k, rq_id[n0 + k], exp_id); end
        n_tests++; if (rq_res[n0 + k] !== 32'hFFFE0001) begin n_fail++; $display("FAIL alt_result%0d got=%0h exp=fffe0001", k, rq_res[n0 + k]); end
        n_tests++; if (rq_err[n0 + k] !== 0) begin n_fail++; $display("FAIL alt_err%0d got=%0d exp=0", k, rq_err[n0 + k]); end
        exp_id = ~exp_id;
      end
      ptr_m = exp_id;
    end
  endtask

  task automatic test_stall();
    int n0, l0;
    bit ok;
    logic [31:0] exp_res;
    exp_res = 32'h1234 * 32'h00AB;
    n0 = rq_id.size();
    @(posedge clk); #1;
    ifc.rsp_ready = 1'b0; set_req(0, 1, 16'h1234, 16'h00AB);
    wait_grant(ok);
    @(posedge clk); #1;
    set_req(0, 0, '0, '0);
    if (ok) begin
      ok = 1'b0;
      for (int i = 0; i < 60 && !ok; i++) begin
        @(negedge clk); #1;
        if (ifc.rsp_valid) ok = 1'b1;
      end
    end
    n_tests++; if (!ok) begin n_fail++; $display("FAIL stall_timeout got=none exp=rsp_valid"); end
    @(posedge clk); #1;
    set_req(0, 1, 16'h0002, 16'h0003); set_req(1, 1, 16'h0004, 16'h0005);
    l0 = loads;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk); #1;
      n_tests++; if ({ifc.rsp_valid, ifc.rsp_id, ifc.rsp_err} !== 3'b100) begin n_fail++; $display("FAIL stall_ctrl%0d got=%b exp=100", c, {ifc.rsp_valid, ifc.rsp_id, ifc.rsp_err}); end
      n_tests++; if (ifc.rsp_result !== exp_res) begin n_fail++; $display("FAIL stall_result%0d got=%0h exp=%0h", c, ifc.rsp_result, exp_res); end
      n_tests++; if ({ifc.req0_ready, ifc.req1_ready} !== 2'b00) begin n_fail++; $display("FAIL stall_ready%0d got=%b exp=00", c, {ifc.req0_ready, ifc.req1_ready}); end
      @(posedge clk); #1;
    end
    n_tests++; if (loads !== l0) begin n_fail++; $display("FAIL stall_loads got=%0d exp=%0d", loads, l0); end
    set_req(0, 0, '0, '0); set_req(1, 0, '0, '0); ifc.rsp_ready = 1'b1;
    wait_rsp(n0, 0, ok);
    n_tests++; if (!ok || rq_res[n0] !== exp_res) begin n_fail++; $display("FAIL stall_release got=%0d exp=1 response", rq_id.size() - n0); end
    ptr_m = 1'b1;
  endtask

  task automatic test_random();
    int n0, g0, l0, mode, sel;
    bit ok, ok2, eid;
    logic [15:0] a0, b0, a1, b1, ea, eb;
    logic [31:0] exp_res;
    for (int t = 0; t < 24; t++) begin
      mode = $urandom_range(0, 2);
      sel = $urandom_range(0, 7);
      a0 = 16'($urandom); b0 = 16'($urandom); a1 = 16'($urandom); b1 = 16'($urandom);
      if (sel == 0) begin a0 = 16'h0; a1 = 16'h0; end
      if (sel == 1) begin b0 = 16'h0; b1 = 16'h0; end
      if (sel == 2) begin a0 = 16'hFFFF; b0 = 16'hFFFF; a1 = 16'hFFFF; b1 = 16'hFFFF; end
      eid = (mode == 2) ? ptr_m : (mode == 1);
      ea = eid ? a1 : a0; eb = eid ? b1 : b0;
      exp_res = {16'h0, ea} * {16'h0, eb};
      n0 = rq_id.size(); g0 = gq_id.size(); l0 = loads;
      @(posedge clk); #1;
      ifc.rsp_ready = 1'b0;
      if (mode != 1) set_req(0, 1, a0, b0);
      if (mode != 0) set_req(1, 1, a1, b1);
      wait_grant(ok);
      @(posedge clk); #1;
      set_req(0, 0, '0, '0); set_req(1, 0, '0, '0);
      ok2 = 1'b0;
      if (ok) wait_rsp(n0, 1, ok2);
      n_tests++; if (!(ok && ok2)) begin n_fail++; $display("FAIL rnd%0d_timeout got=grant%0d/rsp%0d exp=both", t, ok, ok2); end
      if (ok && ok2 && gq_id.size() > g0) begin
        n_tests++; if (gq_id[g0] !== int'(eid)) begin n_fail++; $display("FAIL rnd%0d_grant got=%0d exp=%0d", t, gq_id[g0], eid); end
        n_tests++; if (rq_id[n0] !== int'(eid)) begin n_fail++; $display("FAIL rnd%0d_id got=%0d exp=%0d", t, rq_id[n0], eid); end
        n_tests++; if (rq_res[n0] !== exp_res) begin n_fail++; $display("FAIL rnd%0d_result got=%0h exp=%0h", t, rq_res[n0], exp_res); end
        n_tests++; if (rq_err[n0] !== 0) begin n_fail++; $display("FAIL rnd%0d_err got=%0d exp=0", t, rq_err[n0]); end
        n_tests++; if (loads - l0 !== exp_loads(ea, eb)) begin n_fail++; $display("FAIL rnd%0d_loads got=%0d exp=%0d", t, loads - l0, exp_loads(ea, eb)); end
      end
      ptr_m = ~eid;
    end
    @(posedge clk); #1;
    ifc.rsp_ready = 1'b1;
  endtask

  task automatic test_reset_mid_run();
    int n0;
    bit ok;
    n0 = rq_id.size();
    @(posedge clk); #1;
    ifc.rsp_ready = 1'b1; set_req(0, 1, 16'hFFFF, 16'hFFFF);
    wait_grant(ok);
    @(posedge clk); #1;
    set_req(0, 0, '0, '0);
    repeat (4) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    n_tests++; if ({ifc.req0_ready, ifc.req1_ready, ifc.rsp_valid, ifc.rsp_id, ifc.rsp_err, ifc.mul_load} !== 6'b0) begin n_fail++; $display("FAIL midrst_ctrl got=%b exp=0", {ifc.req0_ready, ifc.req1_ready, ifc.rsp_valid, ifc.rsp_id, ifc.rsp_err, ifc.mul_load}); end
    n_tests++; if ({ifc.mul_a, ifc.mul_b, ifc.rsp_result} !== 64'h0) begin n_fail++; $display("FAIL midrst_data got=%0h exp=0", {ifc.mul_a, ifc.mul_b, ifc.rsp_result}); end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    ptr_m = 1'b0;
    repeat (25) @(posedge clk);
    n_tests++; if (rq_id.size() !== n0) begin n_fail++; $display("FAIL midrst_stale got=%0d exp=0 responses", rq_id.size() - n0); end
    test_single("postrst", 1'b1, 16'd2, 16'd2, 1'b0);
    n_tests++; if (rq_id.size() !== n0 + 1) begin n_fail++; $display("FAIL postrst_count got=%0d exp=1", rq_id.size() - n0); end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout got=stalled exp=finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    test_reset();
    test_basic();
    test_zero();
    test_alternate();
    test_watchdog();
    test_stall();
    test_random();
    test_reset_mid_run();
    n_tests++; if (dbl !== 0) begin n_fail++; $display("FAIL double_ready got=%0d exp=0", dbl); end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
